// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its surroundings:
// run request, instruction fetch handshake, divider handshake and timed strobes.
interface instr_sequencer_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
) ();
   logic               start;
   logic               imem_req;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;
   logic               mem_re;
   logic               mem_we;
   logic               reg_we;
   logic               div_start;
   logic               div_done;
   logic               busy;
   logic               fault;

   // Sequencer side
   modport master (
      input  start, imem_ack, imem_data, div_done,
      output imem_req, pc, ir, mem_re, mem_we, reg_we, div_start, busy, fault
   );

   // Environment side: instruction memory, divider and run control
   modport slave (
      output start, imem_ack, imem_data, div_done,
      input  imem_req, pc, ir, mem_re, mem_we, reg_we, div_start, busy, fault
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for the 4-bit-opcode RISC core. Fetches, decodes and steps
// each instruction through EXEC/MEM/WB, issuing registered one-cycle strobes and
// handshaking with the multi-cycle divider. Illegal opcodes and divider timeouts
// park the sequencer in FAULT until reset.
module instr_sequencer #(
   parameter int PC_W        = 8,
   parameter int INSTR_W     = 16,
   parameter int DIV_TIMEOUT = 32
) (
   input logic               clk,
   input logic               rst_n,
   instr_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

   localparam logic [3:0] OP_LDM  = 4'b0000;
   localparam logic [3:0] OP_STM  = 4'b0001;
   localparam logic [3:0] OP_DIV  = 4'b1100;
   localparam logic [3:0] OP_IL0  = 4'b1101;
   localparam logic [3:0] OP_IL1  = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DIV_WAIT, S_FAULT
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
   logic               mem_re_q, mem_re_d;
   logic               mem_we_q, mem_we_d;
   logic               reg_we_q, reg_we_d;
   logic               div_start_q, div_start_d;
   logic [3:0]         opcode;

   assign opcode = ir_q[INSTR_W-1 -: 4];

   // Next-state, datapath-register and strobe decode. Strobes are computed one
   // cycle ahead so that they come straight out of flops in the state they mark.
   always_comb begin
      // NOTE: every signal gets a default first so no path can leave one unassigned and infer a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      div_cnt_d   = div_cnt_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      reg_we_d    = 1'b0;
      div_start_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_data;
               pc_d    = pc_q + 1'b1;  // wraps naturally at 2**PC_W
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (opcode)
               OP_LDM: begin
                  state_d  = S_MEM;
                  mem_re_d = 1'b1;
               end
               OP_STM: begin
                  state_d  = S_MEM;
                  mem_we_d = 1'b1;
               end
               OP_DIV: begin
                  state_d     = S_EXEC;
                  div_start_d = 1'b1;
               end
               OP_IL0, OP_IL1: state_d = S_FAULT;
               OP_HALT:        state_d = S_IDLE;
               default:        state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            if (opcode == OP_DIV) begin
               state_d   = S_DIV_WAIT;
               div_cnt_d = CNT_W'(1);
            end else begin
               state_d  = S_WB;
               reg_we_d = 1'b1;
            end
         end
         S_MEM: begin
            if (opcode == OP_LDM) begin
               state_d  = S_WB;
               reg_we_d = 1'b1;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         S_DIV_WAIT: begin
            // A result arriving on the last allowed cycle still counts.
            if (bus.div_done) begin
               state_d   = S_WB;
               reg_we_d  = 1'b1;
               div_cnt_d = '0;
            end else if (div_cnt_q == CNT_W'(DIV_TIMEOUT)) begin
               state_d   = S_FAULT;
               div_cnt_d = '0;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   // State, program counter, instruction and strobe registers; reset clears all of them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         ir_q        <= '0;
         div_cnt_q   <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         reg_we_q    <= 1'b0;
         div_start_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         div_cnt_q   <= div_cnt_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         reg_we_q    <= reg_we_d;
         div_start_q <= div_start_d;
      end
   end

   assign bus.imem_req  = (state_q == S_FETCH);
   assign bus.busy      = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign bus.fault     = (state_q == S_FAULT);
   assign bus.pc        = pc_q;
   assign bus.ir        = ir_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.div_start = div_start_q;

endmodule
